// File: rtl/wb_stage_ctrl.sv
// rtl/wb_stage_ctrl.sv - WB stage write/flush sequencer driven by D-cache stalls and WB exceptions.
// Optional perf counters are enabled by defining WB_CTRL_PERF_EN.
module wb_stage_ctrl #(
  parameter int FLUSH_CYCLES  = 1,
  parameter int STALL_TIMEOUT = 1023,
  parameter int CNT_W         = 10
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       DC_Busy,
  input  logic       Except_Valid,
  input  logic       Eret_Valid,
  output logic       WB_Wr,
  output logic       WB_Flush,
  output logic       MEM_Flush,
  output logic       WB_DisWr,
  output logic [1:0] Ctrl_State,
  output logic       Stall_Timeout
`ifdef WB_CTRL_PERF_EN
  ,
  output logic [31:0] Perf_StallCyc,
  output logic [15:0] Perf_FlushCnt
`endif
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FCNT_INIT = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SCNT_TO   = CNT_W'(STALL_TIMEOUT);
  localparam logic [CNT_W-1:0] SCNT_MAX  = {CNT_W{1'b1}};
  localparam bit               MULTI_FL  = (FLUSH_CYCLES > 1);

  state_t           state, state_n;
  logic             pend, pend_n;
  logic [CNT_W-1:0] scnt, scnt_n;
  logic [CNT_W-1:0] fcnt, fcnt_n;
  logic             timeout, timeout_n;
  logic             flush;
  logic             flush_ev;
  logic             stall_cyc;
  logic             ev;

  assign ev = Except_Valid | Eret_Valid;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= ST_INIT;
      pend    <= 1'b0;
      scnt    <= '0;
      fcnt    <= '0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      pend    <= pend_n;
      scnt    <= scnt_n;
      fcnt    <= fcnt_n;
      timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    pend_n    = pend;
    scnt_n    = scnt;
    fcnt_n    = fcnt;
    WB_Wr     = 1'b1;
    flush     = 1'b0;
    WB_DisWr  = 1'b0;
    flush_ev  = 1'b0;
    stall_cyc = 1'b0;
    case (state)
      ST_INIT: begin
        WB_Wr    = 1'b0;
        flush    = 1'b1;
        WB_DisWr = 1'b1;
        state_n  = ST_RUN;
      end
      ST_RUN: begin
        if (DC_Busy) begin
          // The WB instruction commits its write in this first stall cycle only.
          WB_Wr     = 1'b0;
          stall_cyc = 1'b1;
          pend_n    = pend | ev;
          scnt_n    = CNT_W'(1);
          state_n   = ST_STALL;
        end else if (ev) begin
          flush    = 1'b1;
          flush_ev = 1'b1;
          if (MULTI_FL) begin
            fcnt_n  = FCNT_INIT;
            state_n = ST_FLUSH;
          end
        end
      end
      ST_STALL: begin
        WB_DisWr = 1'b1;
        if (DC_Busy) begin
          WB_Wr     = 1'b0;
          stall_cyc = 1'b1;
          pend_n    = pend | ev;
          if (scnt != SCNT_MAX) scnt_n = scnt + CNT_W'(1);
        end else begin
          scnt_n  = '0;
          pend_n  = 1'b0;
          state_n = ST_RUN;
          if (pend) begin
            flush    = 1'b1;
            flush_ev = 1'b1;
            if (MULTI_FL) begin
              fcnt_n  = FCNT_INIT;
              state_n = ST_FLUSH;
            end
          end
        end
      end
      default: begin
        flush    = 1'b1;
        WB_DisWr = 1'b1;
        fcnt_n   = fcnt - CNT_W'(1);
        if (fcnt <= CNT_W'(1)) state_n = ST_RUN;
      end
    endcase
  end

  // Sticky: latches on the edge where the stall count reaches the threshold.
  assign timeout_n = timeout | (stall_cyc && (scnt_n == SCNT_TO));

  assign WB_Flush      = flush;
  assign MEM_Flush     = flush;
  assign Ctrl_State    = state;
  assign Stall_Timeout = timeout;

`ifdef WB_CTRL_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_flush;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (stall_cyc && (perf_stall != 32'hFFFF_FFFF)) perf_stall <= perf_stall + 32'd1;
      if (flush_ev && (perf_flush != 16'hFFFF)) perf_flush <= perf_flush + 16'd1;
    end
  end

  assign Perf_StallCyc = perf_stall;
  assign Perf_FlushCnt = perf_flush;
`else
  logic unused_perf;
  assign unused_perf = flush_ev;
`endif

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// tb/tb_wb_stage_ctrl.sv - Scoreboard bench for wb_stage_ctrl (FLUSH_CYCLES=3, STALL_TIMEOUT=5).
module tb_wb_stage_ctrl;

  typedef struct {
    int          idx;
    logic [6:0]  outs;   // {wr, wb_flush, mem_flush, diswr, state[1:0], timeout}
    bit          chk_perf;
    logic [31:0] ps;
    logic [15:0] pf;
  } exp_t;

  localparam logic [1:0] I = 2'd0, R = 2'd1, S = 2'd2, F = 2'd3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic dc_busy = 1'b0;
  logic except_valid = 1'b0;
  logic eret_valid = 1'b0;
  logic wb_wr, wb_flush, mem_flush, wb_diswr, stall_timeout;
  logic [1:0] ctrl_state;
`ifdef WB_CTRL_PERF_EN
  logic [31:0] perf_stallcyc;
  logic [15:0] perf_flushcnt;
`endif

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   vec_n = 0;
  bit          chk_perf = 1'b0;
  logic [31:0] exp_ps = '0;
  logic [15:0] exp_pf = '0;

  always #5 clk = ~clk;

  wb_stage_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(5), .CNT_W(10)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .DC_Busy      (dc_busy),
    .Except_Valid (except_valid),
    .Eret_Valid   (eret_valid),
    .WB_Wr        (wb_wr),
    .WB_Flush     (wb_flush),
    .MEM_Flush    (mem_flush),
    .WB_DisWr     (wb_diswr),
    .Ctrl_State   (ctrl_state),
    .Stall_Timeout(stall_timeout)
`ifdef WB_CTRL_PERF_EN
    ,
    .Perf_StallCyc(perf_stallcyc),
    .Perf_FlushCnt(perf_flushcnt)
`endif
  );

  task automatic step(input logic rn, input logic b, input logic e, input logic r,
                      input logic wr, input logic fl, input logic dis,
                      input logic [1:0] st, input logic to);
    exp_t x;
    @(posedge clk);
    #1;
    resetn       = rn;
    dc_busy      = b;
    except_valid = e;
    eret_valid   = r;
    x.idx      = vec_n;
    x.outs     = {wr, fl, fl, dis, st, to};
    x.chk_perf = chk_perf;
    x.ps       = exp_ps;
    x.pf       = exp_pf;
    q.push_back(x);
    vec_n++;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      logic [6:0] act;
      x = q.pop_front();
      act = {wb_wr, wb_flush, mem_flush, wb_diswr, ctrl_state, stall_timeout};
      compared++;
      if (act !== x.outs) begin
        mismatched++;
        $display("FAIL vec%0d outs {wr,wbfl,memfl,dis,st,to}: got %b want %b", x.idx, act, x.outs);
      end
`ifdef WB_CTRL_PERF_EN
      if (x.chk_perf) begin
        compared++;
        if (perf_stallcyc !== x.ps || perf_flushcnt !== x.pf) begin
          mismatched++;
          $display("FAIL vec%0d perf: got stall=%0d flush=%0d want stall=%0d flush=%0d",
                   x.idx, perf_stallcyc, perf_flushcnt, x.ps, x.pf);
        end
      end
`endif
    end
  end

  initial begin
    // reset and release
    step(0,0,0,0, 0,1,1,I,0);
    step(1,0,0,0, 0,1,1,I,0);
    step(1,0,0,0, 1,0,0,R,0);
    step(1,0,0,0, 1,0,0,R,0);
    // 4-cycle stall
    step(1,1,0,0, 0,0,0,R,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,0,0,0, 1,0,1,S,0);
    step(1,0,0,0, 1,0,0,R,0);
    // exception in 2nd stall cycle, deferred to exit, then 3-cycle flush ignoring busy
    step(1,1,0,0, 0,0,0,R,0);
    step(1,1,1,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,0,0,0, 1,1,1,S,0);
    step(1,1,0,0, 1,1,1,F,0);
    step(1,0,1,0, 1,1,1,F,0);
    step(1,0,0,0, 1,0,0,R,0);
    // ERET in the first stall cycle is deferred too
    step(1,1,0,1, 0,0,0,R,0);
    step(1,0,0,0, 1,1,1,S,0);
    step(1,0,0,0, 1,1,1,F,0);
    step(1,0,0,0, 1,1,1,F,0);
    step(1,0,0,0, 1,0,0,R,0);
    // ERET in RUN: 3 flush cycles, busy/events ignored in FLUSH
    step(1,0,0,1, 1,1,0,R,0);
    step(1,1,0,0, 1,1,1,F,0);
    step(1,1,1,1, 1,1,1,F,0);
    step(1,0,0,0, 1,0,0,R,0);
    // except+eret together act as one event
    step(1,0,1,1, 1,1,0,R,0);
    step(1,0,0,0, 1,1,1,F,0);
    step(1,0,0,0, 1,1,1,F,0);
    step(1,0,0,0, 1,0,0,R,0);
    // 8-cycle stall: timeout latches at the end of the 5th stall cycle and sticks
    step(1,1,0,0, 0,0,0,R,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,1);
    step(1,1,0,0, 0,0,1,S,1);
    step(1,1,0,0, 0,0,1,S,1);
    step(1,0,0,0, 1,0,1,S,1);
    step(1,0,0,0, 1,0,0,R,1);
    // asynchronous reset mid-stall
    step(1,1,0,0, 0,0,0,R,1);
    step(1,1,0,0, 0,0,1,S,1);
    step(0,1,0,0, 0,1,1,I,0);
    step(1,0,0,0, 0,1,1,I,0);
    step(1,0,0,0, 1,0,0,R,0);
    // two 3-cycle stalls plus one exception after a fresh reset
    step(1,1,0,0, 0,0,0,R,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,0,0,0, 1,0,1,S,0);
    step(1,1,0,0, 0,0,0,R,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,1,0,0, 0,0,1,S,0);
    step(1,0,0,0, 1,0,1,S,0);
    step(1,0,1,0, 1,1,0,R,0);
    step(1,0,0,0, 1,1,1,F,0);
    step(1,0,0,0, 1,1,1,F,0);
    chk_perf = 1'b1;
    exp_ps = 32'd6;
    exp_pf = 16'd1;
    step(1,0,0,0, 1,0,0,R,0);
    chk_perf = 1'b0;

    for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
    @(posedge clk);
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
